// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the loader state encoding, stream framing constants and the byte-lane insert helper.
// Define IMEM_LOADER_CHECKSUM_EN to add the trailing XOR checksum byte and its CHK state.
package imem_loader_pkg;

    // Length field is two bytes, little-endian; instruction words are four bytes.
    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK    = 3'd4,
`endif
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    // Place byte b into lane 'lane' of word (lane 0 = bits [7:0]).
    function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words and emits a one-cycle word_vld pulse.
// Latency: word_vld/word_dat are registered, valid the cycle after the 4th byte is accepted.
// Backpressure: none; the caller only presents byte_vld on an accepted transfer.
// Ports: clk, reset (async, active-high), clear (restart at lane 0), byte_vld/byte_dat (accepted byte),
//        byte_last (current byte completes a word), word_vld/word_dat (completed word, held until next).
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        byte_last,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] asm_q, asm_d;
    logic        word_vld_q, word_vld_d;
    logic [31:0] word_dat_q, word_dat_d;

    assign byte_last = (byte_idx_q == 2'(WORD_BYTES - 1));
    assign word_vld  = word_vld_q;
    assign word_dat  = word_dat_q;

    always_comb begin
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        word_vld_d = 1'b0;
        word_dat_d = word_dat_q;
        if (clear) begin
            // Every lane is overwritten before the next word is emitted, so only the index needs clearing.
            byte_idx_d = 2'd0;
        end else if (byte_vld) begin
            asm_d = lane_insert(asm_q, byte_idx_q, byte_dat);
            if (byte_last) begin
                word_dat_d = asm_d;
                word_vld_d = 1'b1;
                byte_idx_d = 2'd0;
            end else begin
                byte_idx_d = byte_idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx_q <= 2'd0;
            asm_q      <= 32'd0;
            word_vld_q <= 1'b0;
            word_dat_q <= 32'd0;
        end else begin
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            word_vld_q <= word_vld_d;
            word_dat_q <= word_dat_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a byte stream (16-bit LE word count, then LE words) and writes instruction memory,
// holding the core in reset until the whole image is written. Latency: write strobe/addr/data one cycle
// after the 4th byte of a word; in_ready is high in every loading state so bytes flow 1/clk.
// Ports: clk, reset (async, active-high), start, in_valid/in_data/in_ready (byte stream),
//        wr_en/wr_addr/wr_data (imem write port), core_reset, busy, done, error.
// Optional: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR-of-data checksum byte checked in CHK.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHK;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t                   state_q, state_d;
    logic [8*LEN_BYTES-1:0]   len_q, len_d;
    logic [15:0]              word_count_q, word_count_d;
    logic [31:0]              wr_addr_q, wr_addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]               chk_q, chk_d;
`endif

    logic xfer;
    logic data_xfer;
    logic asm_clear;
    logic byte_last;

    always_comb begin
        busy = 1'b0;
        case (state_q)
            LEN_LO, LEN_HI, DATA: busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:                  busy = 1'b1;
`endif
            default:              busy = 1'b0;
        endcase
    end

    assign in_ready   = busy;
    assign xfer       = in_valid & in_ready;
    assign data_xfer  = xfer & (state_q == DATA);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);
    // Only a completed image releases the core; IDLE after power-on and ERR both keep it held.
    assign core_reset = (state_q != DONE);
    assign wr_addr    = wr_addr_q;

    imem_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .byte_vld  (data_xfer),
        .byte_dat  (in_data),
        .byte_last (byte_last),
        .word_vld  (wr_en),
        .word_dat  (wr_data)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_count_d = word_count_q;
        wr_addr_d    = wr_addr_q;
        asm_clear    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d        = chk_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d      = LEN_LO;
                    word_count_d = 16'd0;
                    asm_clear    = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d        = 8'd0;
`endif
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    if (len_d == 16'd0) begin
                        state_d = AFTER_DATA;
                    end else if (32'(len_d) > MAX_WORDS) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ in_data;
`endif
                    if (byte_last) begin
                        // Address registers alongside the assembled word so both land with wr_en.
                        wr_addr_d    = {14'd0, word_count_q, 2'b00};
                        word_count_d = word_count_q + 16'd1;
                        if (word_count_q + 16'd1 == len_q) begin
                            state_d = AFTER_DATA;
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    state_d = (in_data == chk_q) ? DONE : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_count_q <= 16'd0;
            wr_addr_q    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_count_q <= word_count_d;
            wr_addr_q    <= wr_addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset values, 2-word image (back-to-back and gapped),
// zero and boundary lengths, oversize length, mid-load reset and (optionally) checksum.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    logic [31:0] last_addr = 32'd0;
    logic [31:0] last_data = 32'd0;

    localparam logic [7:0] IMG [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                                        8'h93, 8'h05, 8'h40, 8'h00};

    always #5 clk = ~clk;

    imem_loader #(.MAX_WORDS(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Write-port log, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_count  = wr_count + 1;
            last_addr = wr_addr;
            last_data = wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte until it is accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [7:0] b);
        logic rdy;
        logic ok;
        ok       = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            rdy = in_ready;
            tick();
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = 8'hEE;
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: byte 0x%02h not accepted, observed in_ready %0b required 1", b, in_ready);
        end
    endtask

    // Full 2-word load; gap = idle cycles between bytes.
    task automatic run_load(input string tag, input int gap);
        int w0;
        w0 = wr_count;
        pulse_start();
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_core_rst_load"}, {31'd0, core_reset}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            send(IMG[i]);
            if (i == 5) begin
                check({tag, "_w0_en"}, {31'd0, wr_en}, 32'd1);
                check({tag, "_w0_addr"}, wr_addr, 32'h0000_0000);
                check({tag, "_w0_data"}, wr_data, 32'h0000_0513);
                check({tag, "_ready_after_w0"}, {31'd0, in_ready}, 32'd1);
                check({tag, "_not_done_mid"}, {31'd0, done}, 32'd0);
            end
            if (i == 9) begin
                check({tag, "_w1_en"}, {31'd0, wr_en}, 32'd1);
                check({tag, "_w1_addr"}, wr_addr, 32'h0000_0004);
                check({tag, "_w1_data"}, wr_data, 32'h0040_0593);
`ifndef IMEM_LOADER_CHECKSUM_EN
                check({tag, "_done_on_last_wr"}, {31'd0, done}, 32'd1);
                check({tag, "_core_rst_low"}, {31'd0, core_reset}, 32'd0);
                check({tag, "_ready_drop"}, {31'd0, in_ready}, 32'd0);
`endif
            end
            if (i < 9) begin
                for (int g = 0; g < gap; g++) tick();
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 2; i < 10; i++) x = x ^ IMG[i];
            check({tag, "_chk_wait"}, {31'd0, done}, 32'd0);
            send(x);
            check({tag, "_chk_done"}, {31'd0, done}, 32'd1);
            check({tag, "_chk_core_rst"}, {31'd0, core_reset}, 32'd0);
        end
`endif
        tick();
        check({tag, "_wr_en_pulse"}, {31'd0, wr_en}, 32'd0);
        check({tag, "_addr_hold"}, wr_addr, 32'h0000_0004);
        check({tag, "_data_hold"}, wr_data, 32'h0040_0593);
        check({tag, "_done_sticky"}, {31'd0, done}, 32'd1);
        check({tag, "_writes"}, 32'(wr_count - w0), 32'd2);
    endtask

    initial begin
        int w0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();

        // Reset values
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", wr_addr, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b0;

        // Idle with stray valid bytes: nothing consumed, core held.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (5) tick();
        in_valid = 1'b0;
        check("idle_no_writes", 32'(wr_count), 32'd0);
        check("idle_core_reset", {31'd0, core_reset}, 32'd1);
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);

        // Back-to-back and gapped loads
        run_load("b2b", 0);
        run_load("gap", 1);

        // Zero-length image
        w0 = wr_count;
        pulse_start();
        check("len0_clears_done", {31'd0, done}, 32'd0);
        send(8'h00);
        send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("len0_in_chk", {31'd0, in_ready}, 32'd1);
        send(8'h00);
`endif
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_core_reset", {31'd0, core_reset}, 32'd0);
        check("len0_writes", 32'(wr_count - w0), 32'd0);

        // Oversize length 0x0101
        w0 = wr_count;
        pulse_start();
        send(8'h01);
        send(8'h01);
        check("big_error", {31'd0, error}, 32'd1);
        check("big_in_ready", {31'd0, in_ready}, 32'd0);
        check("big_core_reset", {31'd0, core_reset}, 32'd1);
        check("big_done", {31'd0, done}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) tick();
        in_valid = 1'b0;
        check("big_writes", 32'(wr_count - w0), 32'd0);
        check("big_error_sticky", {31'd0, error}, 32'd1);

        // Length exactly MAX_WORDS is accepted
        pulse_start();
        check("max_clears_error", {31'd0, error}, 32'd0);
        send(8'h00);
        send(8'h01);
        check("max_in_data", {31'd0, busy}, 32'd1);
        check("max_no_error", {31'd0, error}, 32'd0);

        // Reset after 6 data bytes of a 2-word load
        reset = 1'b1;
        tick();
        reset = 1'b0;
        w0 = wr_count;
        pulse_start();
        for (int i = 0; i < 8; i++) send(IMG[i]);
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("mid_rst_wr_addr", wr_addr, 32'd0);
        check("mid_rst_wr_data", wr_data, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("mid_rst_writes", 32'(wr_count - w0), 32'd1);
        check("mid_rst_last_addr", last_addr, 32'h0000_0000);
        check("mid_rst_last_data", last_data, 32'h0000_0513);
        run_load("reload", 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum byte
        w0 = wr_count;
        pulse_start();
        for (int i = 0; i < 10; i++) send(IMG[i]);
        send(8'h00);
        check("badchk_error", {31'd0, error}, 32'd1);
        check("badchk_core_reset", {31'd0, core_reset}, 32'd1);
        check("badchk_done", {31'd0, done}, 32'd0);
        tick();
        check("badchk_writes", 32'(wr_count - w0), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
